// File: rtl/ctech_lib_cdc_pkg.sv
// ---------------------------------------------------------------------------
// ctech_lib_cdc_pkg
// Shared types and constants for the toggle-handshake CDC transmitter and its
// ack synchronizer.
//   cdc_tx_state_e      : transmitter FSM states
//   CDC_MIN_SYNC_STAGES : floor on synchronizer depth
// ---------------------------------------------------------------------------
package ctech_lib_cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_ACK = 2'd2
    } cdc_tx_state_e;

    localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/ctech_lib_cdc_ack_sync.sv
// ---------------------------------------------------------------------------
// ctech_lib_cdc_ack_sync
// Multi-flop synchronizer bringing an asynchronous level into the local clock
// domain. Depth is never allowed below CDC_MIN_SYNC_STAGES.
// Ports:
//   i_clk    : destination clock
//   i_rst_b  : asynchronous active-low reset, clears the whole chain
//   i_async  : asynchronous input (WIDTH bits, each bit independent)
//   o_sync   : synchronized output, STAGES flops after i_async
// ---------------------------------------------------------------------------
module ctech_lib_cdc_ack_sync
    import ctech_lib_cdc_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_b,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    localparam int STAGES_EFF = (STAGES < CDC_MIN_SYNC_STAGES) ? CDC_MIN_SYNC_STAGES : STAGES;

    // First flop samples an asynchronous signal: keep the chain together and
    // untouched so placement gives it maximum metastability settling time.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", cdc_waiver = "toggle_ack_sync" *)
    logic [STAGES_EFF-1:0][WIDTH-1:0] r_sync;

    // Shift chain: element 0 captures the async input, top element is the output.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_sync <= {(STAGES_EFF*WIDTH){1'b0}};
        end else begin
            r_sync <= {r_sync[STAGES_EFF-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES_EFF-1];

endmodule

// File: rtl/ctech_lib_cdc_tx_handshake.sv
// ---------------------------------------------------------------------------
// ctech_lib_cdc_tx_handshake
// Source end of a 2-phase (toggle) req/ack crossing. A word accepted on the
// valid/ready side is held on tx_data, then tx_req_tgl flips one cycle later;
// the next word is accepted only once the synchronized ack matches the req.
// Ports:
//   clk, rst_b          : source clock, asynchronous active-low reset
//   in_valid/in_data    : upstream word; in_ready high only in IDLE
//   tx_data, tx_req_tgl : registered payload and request toggle
//   ack_tgl             : asynchronous ack toggle from the destination
//   done                : one-cycle pulse on transfer completion
//   busy                : transfer in flight
//   err_clr             : clears the sticky error flags
//   timeout_err         : ack not seen within TIMEOUT_CYCLES (0 = disabled)
//   protocol_err        : ack moved while no request was outstanding
// ---------------------------------------------------------------------------
module ctech_lib_cdc_tx_handshake
    import ctech_lib_cdc_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req_tgl,
    input  logic             ack_tgl,
    output logic             done,
    output logic             busy,
    input  logic             err_clr,
    output logic             timeout_err,
    output logic             protocol_err
);

    localparam bit               TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam int               TO_LAST   = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cdc_tx_state_e    r_state;
    cdc_tx_state_e    w_state_nxt;
    logic [WIDTH-1:0] r_tx_data;
    logic             r_tx_req_tgl;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_timeout_err;
    logic             r_protocol_err;

    logic w_ack_s;
    logic w_ack_match;
    logic w_accept;
    logic w_launch;
    logic w_cnt_inc;
    logic w_done_nxt;
    logic w_to_set;
    logic w_pe_set;

    ctech_lib_cdc_ack_sync #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (clk),
        .i_rst_b (rst_b),
        .i_async (ack_tgl),
        .o_sync  (w_ack_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the strobes that steer the datapath registers.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_match = (w_ack_s == r_tx_req_tgl);
        w_accept    = 1'b0;
        w_launch    = 1'b0;
        w_cnt_inc   = 1'b0;
        w_done_nxt  = 1'b0;
        w_to_set    = 1'b0;
        w_pe_set    = 1'b0;
        case (r_state)
            IDLE: begin
                // No request outstanding: any ack movement is a protocol fault.
                w_pe_set = ~w_ack_match;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LAUNCH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LAUNCH: begin
                // tx_data has been stable a full cycle; the req flips on this edge.
                w_pe_set    = ~w_ack_match;
                w_launch    = 1'b1;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                w_to_set = TO_EN && (r_cnt == TO_LAST_C);
                if (w_ack_match) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_inc   = (r_cnt != CNT_MAX);
                    w_state_nxt = WAIT_ACK;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Payload register: loads only on the accept edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_tx_data <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_tx_data <= in_data;
        end
    end

    // Request toggle and saturating wait counter, both restarted at launch.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_tx_req_tgl <= 1'b0;
            r_cnt        <= CNT_ZERO;
        end else if (w_launch) begin
            r_tx_req_tgl <= ~r_tx_req_tgl;
            r_cnt        <= CNT_ZERO;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Completion pulse and sticky error flags; a set condition beats err_clr.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_done         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_done         <= w_done_nxt;
            r_timeout_err  <= w_to_set ? 1'b1 : (err_clr ? 1'b0 : r_timeout_err);
            r_protocol_err <= w_pe_set ? 1'b1 : (err_clr ? 1'b0 : r_protocol_err);
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign tx_data      = r_tx_data;
    assign tx_req_tgl   = r_tx_req_tgl;
    assign done         = r_done;
    assign timeout_err  = r_timeout_err;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_ctech_lib_cdc_tx_handshake.sv
// ---------------------------------------------------------------------------
// tb_ctech_lib_cdc_tx_handshake
// Self-checking bench for the toggle-handshake transmitter (WIDTH=8,
// SYNC_STAGES=2, TIMEOUT_CYCLES=8). The reference model works in terms of
// event times: a word accepted on edge 1 appears on tx_data after edge 1, req
// flips after edge 2, and done fires SYNC_STAGES edges after the edge that
// first samples the destination's ack.
// ---------------------------------------------------------------------------
module tb_ctech_lib_cdc_tx_handshake;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int TO    = 8;

    logic             clk;
    logic             rst_b;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_req_tgl;
    logic             ack_tgl;
    logic             done;
    logic             busy;
    logic             err_clr;
    logic             timeout_err;
    logic             protocol_err;

    ctech_lib_cdc_tx_handshake #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .tx_data      (tx_data),
        .tx_req_tgl   (tx_req_tgl),
        .ack_tgl      (ack_tgl),
        .done         (done),
        .busy         (busy),
        .err_clr      (err_clr),
        .timeout_err  (timeout_err),
        .protocol_err (protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] data;
        int         k;    // cycles after req flip before the ack moves
        int         d;    // sub-cycle phase of the ack edge (0..9, 5 = rising edge, unused)
        int         lat;  // expected cycles from req flip to done
    } vec_t;

    int         nvec     = 0;
    int         nerr     = 0;
    int         done_cnt = 0;
    logic       exp_req  = 1'b0;
    logic [7:0] exp_data = 8'h00;

    task automatic chk1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_busy, input logic e_done,
                            input logic e_terr, input logic e_perr);
        chk1({tag, ".busy"}, busy, e_busy);
        chk1({tag, ".in_ready"}, in_ready, ~e_busy);
        chk1({tag, ".done"}, done, e_done);
        chk8({tag, ".tx_data"}, tx_data, exp_data);
        chk1({tag, ".tx_req_tgl"}, tx_req_tgl, exp_req);
        chk1({tag, ".timeout_err"}, timeout_err, e_terr);
        chk1({tag, ".protocol_err"}, protocol_err, e_perr);
        if (done === 1'b1) done_cnt++;
    endtask

    // One complete transfer starting from IDLE at the current negedge.
    task automatic do_xfer(input logic [7:0] data, input int k, input int d, input int lat,
                           input bit rnd_in, output logic req_seen);
        int last = lat + 2;
        req_seen = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        exp_data = data;
        for (int s = 1; s <= last; s++) begin
            @(negedge clk);
            if (s == 2) exp_req = ~exp_req;
            chk_outs("xfer", s < last, s == last, 1'b0, 1'b0);
            if (s == 2) req_seen = tx_req_tgl;
            if (s < last && rnd_in) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
            end
            if (s == 2 + k) begin
                if (d > 0) #(d);
                ack_tgl = exp_req;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_b    = 1'b0;
        ack_tgl  = 1'b0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(negedge clk);
        rst_b    = 1'b1;
        exp_req  = 1'b0;
        exp_data = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl [4];
        logic exp_b2b [4];
        logic req_seen;
        int   d0;
        int   k;
        int   d;

        tbl[0] = '{8'hA5, 2, 2, 5};
        tbl[1] = '{8'h3C, 0, 1, 3};
        tbl[2] = '{8'h00, 1, 7, 5};
        tbl[3] = '{8'hFF, 3, 9, 7};
        exp_b2b[0] = 1'b1;
        exp_b2b[1] = 1'b0;
        exp_b2b[2] = 1'b1;
        exp_b2b[3] = 1'b0;

        // Reset state
        rst_b    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ack_tgl  = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_b = 1'b1;
        @(negedge clk);
        chk_outs("reset_rel", 1'b0, 1'b0, 1'b0, 1'b0);

        // Table-driven single transfers
        for (int i = 0; i < 4; i++) begin
            do_xfer(tbl[i].data, tbl[i].k, tbl[i].d, tbl[i].lat, 1'b1, req_seen);
            idle_cycles(2);
        end

        // Back-to-back words with in_valid held high
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            do_xfer(8'(i + 1), 1, 3, 4, 1'b0, req_seen);
            chk1("b2b_req_seq", req_seen, exp_b2b[i]);
        end
        idle_cycles(1);
        chkn("b2b_done_count", done_cnt - d0, 4);

        // Timeout: ack withheld, then late ack, then err_clr
        in_valid = 1'b1;
        in_data  = 8'h5A;
        exp_data = 8'h5A;
        for (int s = 1; s <= 16; s++) begin
            @(negedge clk);
            if (s == 2) exp_req = ~exp_req;
            in_valid = 1'b0;
            chk_outs("timeout", s < 15, s == 15, (s >= 10) && (s <= 15), 1'b0);
            if (s == 12) begin
                #1;
                ack_tgl = exp_req;
            end
            err_clr = (s == 15);
        end

        // Spurious ack in IDLE, err_clr racing a live violation
        ack_tgl = ~exp_req;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            chk_outs("spurious", 1'b0, 1'b0, 1'b0, (s >= 3) && (s <= 6));
            err_clr = (s >= 3) && (s <= 6);
            if (s == 4) ack_tgl = exp_req;
        end

        // Reset in WAIT_ACK, observed without any clock edge
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'hC3;
        exp_data = 8'hC3;
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            if (s == 2) exp_req = ~exp_req;
            chk_outs("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0);
            in_valid = 1'b0;
        end
        #2;
        rst_b   = 1'b0;
        ack_tgl = 1'b0;
        #1;
        chk1("rst_async.tx_req_tgl", tx_req_tgl, 1'b0);
        chk8("rst_async.tx_data", tx_data, 8'h00);
        chk1("rst_async.busy", busy, 1'b0);
        chk1("rst_async.in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_b    = 1'b1;
        exp_req  = 1'b0;
        exp_data = 8'h00;
        @(negedge clk);
        chk_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        do_xfer(8'h96, 1, 2, 4, 1'b0, req_seen);
        idle_cycles(1);

        // Randomized transfers with random ack phase
        d0 = done_cnt;
        for (int n = 0; n < 1000; n++) begin
            k = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 8));
            if (d >= 5) d++;
            do_xfer(8'($urandom), k, d, 1 + k + ((d >= 5) ? 1 : 0) + SYNC, 1'b1, req_seen);
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(1);
        chkn("rand_done_count", done_cnt - d0, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
